// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
//   Bundles the signals between the multicycle control unit and the rest of
//   the CPU: the opcode field of the instruction register, the unified
//   memory ready flag, and every datapath mux select / enable.
//
//   Parameters
//     STATE_W   width of the State debug field
//
//   Modports
//     master    control unit: samples OpCode/MemReady, drives all controls
//     slave     datapath/memory side: drives OpCode/MemReady, reads controls
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         OpCode;
    logic               MemReady;
    logic               PCWrite;
    logic               BranchEq;
    logic               BranchNe;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               AluSrcA;
    logic [1:0]         AluSrcB;
    logic [1:0]         AluOp;
    logic [1:0]         PCSource;
    logic               IllegalOp;
    logic               MemTimeout;
    logic [STATE_W-1:0] State;

    modport master (
        input  OpCode, MemReady,
        output PCWrite, BranchEq, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSource,
               IllegalOp, MemTimeout, State
    );

    modport slave (
        output OpCode, MemReady,
        input  PCWrite, BranchEq, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSource,
               IllegalOp, MemTimeout, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   Moore FSM sequencing a MIPS subset (lw, sw, R-type, beq, bne, j and,
//   optionally, addi) through fetch / decode / execute / memory / writeback
//   over one shared ALU and one unified memory. Memory states wait on
//   MemReady with a bounded wait counter; an expired wait pulses MemTimeout
//   and restarts at FETCH. Unknown opcodes pulse IllegalOp in DECODE.
//
//   Ports
//     clk      rising-edge clock
//     reset    asynchronous active-high reset; all outputs forced to 0 while high
//     bus      multicycle_control_unit_if.master: OpCode, MemReady in;
//              datapath controls, IllegalOp, MemTimeout, State out
//
//   Parameters
//     WAIT_MAX  cycles waited for MemReady before timeout (1..255)
//     WCNT_W    wait counter width, must hold WAIT_MAX
//     STATE_W   width of the State debug output
//
//   Build option
//     IMM_ALU_EN  when defined, addi (001000) runs DECODE -> ADDIEX -> ADDIWB;
//                 otherwise addi is treated as an illegal opcode.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int WAIT_MAX = 15,
    parameter int WCNT_W   = 8,
    parameter int STATE_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] JUMP   = 4'd9;
`ifdef IMM_ALU_EN
    localparam logic [3:0] ADDIEX = 4'd10;
    localparam logic [3:0] ADDIWB = 4'd11;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0]        state;
    logic [3:0]        nextState;
    logic [5:0]        opReg;      // opcode captured in DECODE for later states
    logic [WCNT_W-1:0] waitCnt;
    logic              waitState;
    logic              timeout;
    logic              illegalOp;

    assign waitState = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

    // A MemReady arriving on the limit cycle wins: the access completes.
    assign timeout = waitState && !bus.MemReady && (waitCnt == WCNT_W'(WAIT_MAX));

    // Next-state logic; illegal opcode detection lives with the DECODE decision.
    always_comb begin
        nextState = state;
        illegalOp = 1'b0;
        case (state)
            FETCH:  nextState = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.OpCode)
                    OP_LW, OP_SW:   nextState = MEMADR;
                    OP_RTYPE:       nextState = EXEC;
                    OP_BEQ, OP_BNE: nextState = BRANCH;
                    OP_J:           nextState = JUMP;
`ifdef IMM_ALU_EN
                    OP_ADDI:        nextState = ADDIEX;
`endif
                    default: begin
                        nextState = FETCH;
                        illegalOp = 1'b1;
                    end
                endcase
            end
            MEMADR: nextState = (opReg == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nextState = bus.MemReady ? MEMWB : (timeout ? FETCH : MEMRD);
            MEMWB:  nextState = FETCH;
            MEMWR:  nextState = (bus.MemReady || timeout) ? FETCH : MEMWR;
            EXEC:   nextState = ALUWB;
            ALUWB:  nextState = FETCH;
            BRANCH: nextState = FETCH;
            JUMP:   nextState = FETCH;
`ifdef IMM_ALU_EN
            ADDIEX: nextState = ADDIWB;
            ADDIWB: nextState = FETCH;
`endif
            default: nextState = FETCH;
        endcase
    end

    // The counter runs only while a wait state is held without MemReady; any
    // completion, timeout or stay outside wait states leaves it at zero, so a
    // wait state is always entered with a cleared count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            opReg   <= '0;
            waitCnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            state <= nextState;
            if (state == DECODE) begin
                opReg <= bus.OpCode;
            end
            if (waitState && !bus.MemReady && !timeout) begin
                waitCnt <= waitCnt + WCNT_W'(1);
            end else begin
                waitCnt <= '0;
            end
        end
    end

    assign bus.State = reset ? '0 : STATE_W'(state);

    // Moore outputs per state, with FETCH's IRWrite/PCWrite qualified by
    // MemReady. Everything is forced low while reset is high.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        bus.PCWrite    = 1'b0;
        bus.BranchEq   = 1'b0;
        bus.BranchNe   = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegDst     = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.AluSrcA    = 1'b0;
        bus.AluSrcB    = 2'b00;
        bus.AluOp      = 2'b00;
        bus.PCSource   = 2'b00;
        bus.IllegalOp  = 1'b0;
        bus.MemTimeout = 1'b0;
        if (!reset) begin
            bus.IllegalOp  = illegalOp;
            bus.MemTimeout = timeout;
            case (state)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.AluSrcB = 2'b01;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                end
                DECODE: bus.AluSrcB = 2'b11;
                MEMADR: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluSrcB = 2'b10;
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                end
                MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                EXEC: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluOp   = 2'b10;
                end
                ALUWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                BRANCH: begin
                    bus.AluSrcA  = 1'b1;
                    bus.AluOp    = 2'b01;
                    bus.PCSource = 2'b01;
                    bus.BranchEq = (opReg == OP_BEQ);
                    bus.BranchNe = (opReg == OP_BNE);
                end
                JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
`ifdef IMM_ALU_EN
                ADDIEX: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluSrcB = 2'b10;
                end
                ADDIWB: bus.RegWrite = 1'b1;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Directed vector table, hand-written corner sequences, then random opcodes
//   and MemReady patterns against an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;
    localparam int WAIT_MAX = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

`ifdef IMM_ALU_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.STATE_W(4)) busIf ();

    multicycle_control_unit #(
        .WAIT_MAX (WAIT_MAX),
        .WCNT_W   (8),
        .STATE_W  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    // Full output vector, used by the random phase.
    typedef struct packed {
        logic       PCWrite;
        logic       BranchEq;
        logic       BranchNe;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemtoReg;
        logic       RegDst;
        logic       RegWrite;
        logic       AluSrcA;
        logic [1:0] AluSrcB;
        logic [1:0] AluOp;
        logic [1:0] PCSource;
        logic       IllegalOp;
        logic       MemTimeout;
        logic [3:0] State;
    } outs_t;

    // Directed vector: inputs plus expected state and key flags
    // flags = {MemRead, IorD, IRWrite, MemWrite, RegWrite, MemtoReg,
    //          BranchEq, BranchNe, IllegalOp, MemTimeout}
    typedef struct {
        bit         rst;
        logic [5:0] op;
        bit         rdy;
        logic [3:0] st;
        logic [9:0] flags;
    } vec_t;

    vec_t vecs[$];
    int   nChecks = 0;
    int   nPass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [9:0] dutFlags();
        return {busIf.MemRead, busIf.IorD, busIf.IRWrite, busIf.MemWrite, busIf.RegWrite,
                busIf.MemtoReg, busIf.BranchEq, busIf.BranchNe, busIf.IllegalOp, busIf.MemTimeout};
    endfunction

    function automatic outs_t dutOuts();
        outs_t o;
        o.PCWrite = busIf.PCWrite;     o.BranchEq = busIf.BranchEq;  o.BranchNe = busIf.BranchNe;
        o.IorD = busIf.IorD;           o.MemRead = busIf.MemRead;    o.MemWrite = busIf.MemWrite;
        o.IRWrite = busIf.IRWrite;     o.MemtoReg = busIf.MemtoReg;  o.RegDst = busIf.RegDst;
        o.RegWrite = busIf.RegWrite;   o.AluSrcA = busIf.AluSrcA;    o.AluSrcB = busIf.AluSrcB;
        o.AluOp = busIf.AluOp;         o.PCSource = busIf.PCSource;  o.IllegalOp = busIf.IllegalOp;
        o.MemTimeout = busIf.MemTimeout; o.State = busIf.State;
        return o;
    endfunction

    // Drive inputs on the falling edge, settle, then the caller compares.
    task automatic step(input bit rst, input logic [5:0] op, input bit rdy);
        @(negedge clk);
        reset = rst;
        busIf.OpCode = op;
        busIf.MemReady = rdy;
        #1;
    endtask

    task automatic addVec(input bit rst, input logic [5:0] op, input bit rdy,
                          input logic [3:0] st, input logic [9:0] flags);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.flags = flags;
        vecs.push_back(v);
    endtask

    // ---------------- instruction-level reference model ----------------
    // An instruction is FETCH, DECODE, then a fixed list of steps chosen by
    // the opcode. FETCH/MEMRD/MEMWR steps wait for MemReady, at most WAIT_MAX
    // idle cycles, after which the instruction is abandoned.
    int         mPhase;
    int         mPlan[$];
    logic [5:0] mOp;
    int         mWaited;

    function automatic bit isLegal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_J) || (IMM_EN && op == OP_ADDI);
    endfunction

    function automatic bit isWaitStep(input int p);
        return (p == 0) || (p == 3) || (p == 5);
    endfunction

    task automatic planFor(input logic [5:0] op);
        mPlan.delete();
        if (op == OP_LW) begin mPlan.push_back(2); mPlan.push_back(3); mPlan.push_back(4); end
        else if (op == OP_SW) begin mPlan.push_back(2); mPlan.push_back(5); end
        else if (op == OP_RTYPE) begin mPlan.push_back(6); mPlan.push_back(7); end
        else if (op == OP_BEQ || op == OP_BNE) mPlan.push_back(8);
        else if (op == OP_J) mPlan.push_back(9);
        else if (IMM_EN && op == OP_ADDI) begin mPlan.push_back(10); mPlan.push_back(11); end
    endtask

    function automatic outs_t modelOut(input bit rst, input logic [5:0] op, input bit rdy);
        outs_t o = '0;
        if (rst) return o;
        o.State = 4'(mPhase);
        o.MemTimeout = isWaitStep(mPhase) && !rdy && (mWaited == WAIT_MAX);
        case (mPhase)
            0:  begin o.MemRead = 1; o.AluSrcB = 2'b01; o.IRWrite = rdy; o.PCWrite = rdy; end
            1:  begin o.AluSrcB = 2'b11; o.IllegalOp = !isLegal(op); end
            2:  begin o.AluSrcA = 1; o.AluSrcB = 2'b10; end
            3:  begin o.MemRead = 1; o.IorD = 1; end
            4:  begin o.RegWrite = 1; o.MemtoReg = 1; end
            5:  begin o.MemWrite = 1; o.IorD = 1; end
            6:  begin o.AluSrcA = 1; o.AluOp = 2'b10; end
            7:  begin o.RegWrite = 1; o.RegDst = 1; end
            8:  begin o.AluSrcA = 1; o.AluOp = 2'b01; o.PCSource = 2'b01;
                      o.BranchEq = (mOp == OP_BEQ); o.BranchNe = (mOp == OP_BNE); end
            9:  begin o.PCWrite = 1; o.PCSource = 2'b10; end
            10: begin o.AluSrcA = 1; o.AluSrcB = 2'b10; end
            11: o.RegWrite = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic nextFromPlan();
        if (mPlan.size() > 0) mPhase = mPlan.pop_front();
        else mPhase = 0;
    endtask

    task automatic modelStep(input bit rst, input logic [5:0] op, input bit rdy);
        if (rst) begin
            mPhase = 0; mWaited = 0; mPlan.delete();
        end else if (isWaitStep(mPhase) && !rdy) begin
            if (mWaited == WAIT_MAX) begin
                mWaited = 0; mPhase = 0; mPlan.delete();
            end else begin
                mWaited++;
            end
        end else begin
            mWaited = 0;
            if (mPhase == 0) mPhase = 1;
            else if (mPhase == 1) begin
                mOp = op;
                planFor(op);
                nextFromPlan();
            end else nextFromPlan();
        end
    endtask

    // -------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowRun;
        outs_t expOut;
        reset = 1'b1;
        busIf.OpCode = '0;
        busIf.MemReady = 1'b0;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) addVec(1, OP_LW, 1, 0, 10'b0000000000);
        // lw, MemReady always high: 0,1,2,3,4
        addVec(0, OP_LW, 1, 0, 10'b1010000000);
        addVec(0, OP_LW, 1, 1, 10'b0000000000);
        addVec(0, OP_LW, 1, 2, 10'b0000000000);
        addVec(0, OP_LW, 1, 3, 10'b1100000000);
        addVec(0, OP_LW, 1, 4, 10'b0000110000);
        // sw, MemReady low 3 cycles in MEMWR
        addVec(0, OP_SW, 1, 0, 10'b1010000000);
        addVec(0, OP_SW, 1, 1, 10'b0000000000);
        addVec(0, OP_SW, 1, 2, 10'b0000000000);
        for (int i = 0; i < 3; i++) addVec(0, OP_SW, 0, 5, 10'b0101000000);
        addVec(0, OP_SW, 1, 5, 10'b0101000000);
        // beq then bne
        addVec(0, OP_BEQ, 1, 0, 10'b1010000000);
        addVec(0, OP_BEQ, 1, 1, 10'b0000000000);
        addVec(0, OP_BNE, 1, 8, 10'b0000001000);
        addVec(0, OP_BNE, 1, 0, 10'b1010000000);
        addVec(0, OP_BNE, 1, 1, 10'b0000000000);
        addVec(0, OP_BEQ, 1, 8, 10'b0000000100);
        // illegal opcode
        addVec(0, OP_BAD, 1, 0, 10'b1010000000);
        addVec(0, OP_BAD, 1, 1, 10'b0000000010);
        // FETCH timeout: 4 idle cycles then the pulse
        for (int i = 0; i < WAIT_MAX; i++) addVec(0, OP_RTYPE, 0, 0, 10'b1000000000);
        addVec(0, OP_RTYPE, 0, 0, 10'b1000000001);
        addVec(0, OP_RTYPE, 0, 0, 10'b1000000000);
        // R-type after the timeout
        addVec(0, OP_RTYPE, 1, 0, 10'b1010000000);
        addVec(0, OP_RTYPE, 1, 1, 10'b0000000000);
        addVec(0, OP_RTYPE, 1, 6, 10'b0000000000);
        addVec(0, OP_RTYPE, 1, 7, 10'b0000100000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].rdy);
            check($sformatf("vec%0d state", i), busIf.State, vecs[i].st);
            check($sformatf("vec%0d flags", i), dutFlags(), vecs[i].flags);
            if (vecs[i].rst) check($sformatf("vec%0d all-zero in reset", i), dutOuts(), 0);
        end

        // MemReady arriving exactly on the limit cycle in MEMRD: no timeout
        step(0, OP_LW, 1); step(0, OP_LW, 1); step(0, OP_LW, 1);
        for (int i = 0; i < WAIT_MAX; i++) step(0, OP_LW, 0);
        check("memrd wait state", busIf.State, 3);
        step(0, OP_LW, 1);
        check("ready-at-limit timeout", busIf.MemTimeout, 0);
        step(0, OP_LW, 1);
        check("ready-at-limit writeback state", busIf.State, 4);
        check("ready-at-limit regwrite", busIf.RegWrite, 1);

        // MEMWR timeout returns to FETCH with no writeback
        step(0, OP_SW, 1); step(0, OP_SW, 1); step(0, OP_SW, 1);
        for (int i = 0; i < WAIT_MAX; i++) step(0, OP_SW, 0);
        step(0, OP_SW, 0);
        check("memwr timeout pulse", {busIf.MemTimeout, busIf.MemWrite, busIf.State}, {2'b11, 4'd5});
        step(0, OP_SW, 1);
        check("after memwr timeout state", busIf.State, 0);
        check("after memwr timeout regwrite", busIf.RegWrite, 0);

        // addi: illegal unless the immediate ALU path is built in
        step(0, OP_ADDI, 1);
        check("addi illegal pulse", busIf.IllegalOp, IMM_EN ? 0 : 1);
        step(0, OP_ADDI, 1);
        check("addi next state", busIf.State, IMM_EN ? 10 : 0);

        // reset asserted mid-MEMRD
        step(1, OP_LW, 1); step(1, OP_LW, 1);
        step(0, OP_LW, 1); step(0, OP_LW, 1); step(0, OP_LW, 1); step(0, OP_LW, 1);
        check("pre-abort memrd", {busIf.State, busIf.MemRead}, {4'd3, 1'b1});
        #2 reset = 1'b1;
        #1;
        check("abort outputs zero", dutOuts(), 0);
        step(1, OP_LW, 1);
        step(0, OP_LW, 1);
        check("after abort state", busIf.State, 0);
        check("after abort regwrite", busIf.RegWrite, 0);
        step(0, OP_LW, 1);
        check("after abort decode", {busIf.State, busIf.RegWrite}, {4'd1, 1'b0});

        // random phase against the reference model
        step(1, OP_LW, 0); step(1, OP_LW, 0);
        modelStep(1, OP_LW, 0);
        lowRun = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rst, rdy;
            logic [5:0] op;
            rst = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 7))
                0: op = OP_LW;   1: op = OP_SW;  2: op = OP_RTYPE; 3: op = OP_BEQ;
                4: op = OP_BNE;  5: op = OP_J;   6: op = OP_ADDI;
                default: op = 6'($urandom_range(0, 63));
            endcase
            if (lowRun > 0) begin
                rdy = 0; lowRun--;
            end else if ($urandom_range(0, 49) == 0) begin
                rdy = 0; lowRun = WAIT_MAX + 2;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            step(rst, op, rdy);
            expOut = modelOut(rst, op, rdy);
            check($sformatf("rand%0d outputs", i), dutOuts(), expOut);
            modelStep(rst, op, rdy);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback, reusing one ALU and one unified memory.
- Adds a memory ready/wait handshake with timeout, illegal-opcode detection, bne and j support.
- Sits between the instruction register opcode field, the unified memory port and the datapath muxes and enables.

Parameters:
- WAIT_MAX, 15: max cycles spent waiting for MemReady in any memory state before timeout; 1..255.
- WCNT_W, 8: width of the wait counter; must hold WAIT_MAX.
- STATE_W, 4: width of the State debug output.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- OpCode  input  6  instruction[31:26]; sampled only in DECODE
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- BranchEq  output  1  conditional PC load if Zero
- BranchNe  output  1  conditional PC load if !Zero
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load instruction register
- MemtoReg  output  1  write-back source is MDR
- RegDst  output  1  write register is rd
- RegWrite  output  1  register file write enable
- AluSrcA  output  1  0 = PC, 1 = A
- AluSrcB  output  2  00 = B, 01 = 4, 10 = signext immediate, 11 = signext immediate shifted left 2
- AluOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- IllegalOp  output  1  one-cycle pulse on an unknown opcode
- MemTimeout  output  1  one-cycle pulse on a handshake timeout
- State  output  STATE_W  current state code

Behaviour:
- Reset: asynchronous; state goes to FETCH and the wait counter to 0. While reset is high, every output is 0, including State. The first active edge after release sees FETCH.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- FETCH:
  - Outputs: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSource=00.
  - IRWrite and PCWrite equal MemReady (Mealy qualification).
  - Stay in FETCH until MemReady, then go to DECODE.
- DECODE:
  - Outputs: AluSrcA=0, AluSrcB=11, AluOp=00.
  - Next state by OpCode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 or 000101 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX (only if IMM_ALU_EN); anything else -> FETCH with IllegalOp=1 for that cycle.
  - The opcode is latched in DECODE and used by the later states.
- MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Go to MEMWB on MemReady.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEMWR: MemWrite=1, IorD=1. Go to FETCH on MemReady.
- EXEC: AluSrcA=1, AluSrcB=00, AluOp=10. Go to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCSource=01. BranchEq=1 for 000100, BranchNe=1 for 000101. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- Outputs not listed for a state are 0.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Clears on entry to a wait state and on MemReady; otherwise increments each cycle the state is held.
  - When the count reaches WAIT_MAX with MemReady=0: pulse MemTimeout and go to FETCH. Counter clears and no IRWrite, PCWrite or RegWrite occurs.
  - MemReady in the same cycle the count reaches WAIT_MAX: the access completes and there is no timeout.
- Latency with MemReady=1 every cycle: lw 5, sw 4, R-type 4, beq/bne 3, j 3, addi 4 cycles.
- Reset asserted mid-instruction: FSM aborts immediately, all outputs drop to 0, no partial writeback.

Optional Feature:
- Macro: IMM_ALU_EN.
- Defined: opcode 001000 (addi) runs DECODE -> ADDIEX -> ADDIWB.
  - ADDIEX: AluSrcA=1, AluSrcB=10, AluOp=00.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
- Undefined: 001000 is illegal (IllegalOp pulse, return to FETCH). States 10 and 11 are unreachable and may be omitted.

Test Plan:
- Reset held 3 cycles, then OpCode=100011 with MemReady=1 -> State 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. All outputs 0 during reset.
- sw (101011) with MemReady low for 3 cycles in MEMWR -> MemWrite=1 and IorD=1 held for 4 cycles. Back to FETCH, no RegWrite.
- beq (000100) then bne (000101) -> BranchEq=1 in state 8 of the first, BranchNe=1 in state 8 of the second. Each instruction is 3 cycles.
- MemReady held 0 in FETCH with WAIT_MAX=4 -> MemTimeout pulses after 4 cycles of waiting. IRWrite stays 0 and State stays at 0.
- OpCode=111111 -> IllegalOp single-cycle pulse in DECODE, then FETCH. With IMM_ALU_EN undefined, 001000 gives the same result.
- Reset asserted during MEMRD with MemReady=1 -> MemRead drops the same cycle, State=0, no RegWrite afterwards.
